// File: rtl/top_pkg.sv
// Shared types and constants for the I2C camera-sensor register-write master.
// Clock stretching in the top is enabled with the macro I2C_CLK_STRETCH_EN.
package top_pkg;

    localparam int I2C_QTR_W = 2;
    localparam int I2C_BIT_W = 3;
    localparam logic [6:0] I2C_SLV_ADDR = 7'h10;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, REG_HI, ACK_H,
        REG_LO, ACK_L, DATA, ACK_D, STOP, DONE
    } i2c_state_t;

    // Open-drain drive {scl_oe, sda_oe} for one quarter of a bit slot.
    function automatic logic [1:0] line_drive(input i2c_state_t st,
                                              input logic [I2C_QTR_W-1:0] qtr,
                                              input logic tx_bit);
        logic scl_low;
        scl_low = (qtr == 2'd0) || (qtr == 2'd3);
        case (st)
            START:                      line_drive = {qtr[1], qtr != 2'd0};
            ADDR, REG_HI, REG_LO, DATA: line_drive = {scl_low, ~tx_bit};
            ACK_A, ACK_H, ACK_L, ACK_D: line_drive = {scl_low, 1'b0};
            STOP:                       line_drive = {qtr == 2'd0, qtr != 2'd3};
            default:                    line_drive = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_byte_shifter.sv
// MSB-first byte shift register with its bit counter; 'last' flags the eighth bit.
module i2c_byte_shifter
    import top_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       msb,
    output logic       last
);

    logic [7:0]           sreg;
    logic [I2C_BIT_W-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= din;
            bit_cnt <= '0;
        end else if (shift) begin
            sreg    <= {sreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + I2C_BIT_W'(1);
        end
    end

    assign msb  = sreg[7];
    assign last = &bit_cnt;

endmodule

// File: rtl/i2c_reg_wr.sv
// I2C master writing one 8-bit value to a 16-bit sensor register address.
// Define I2C_CLK_STRETCH_EN to let a slave stall the engine by holding SCL low.
module i2c_reg_wr
    import top_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = I2C_SLV_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe_400kHz,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in
);

    i2c_state_t           state;
    logic [I2C_QTR_W-1:0] qtr;
    logic [15:0]          addr_q;
    logic [7:0]           data_q;
    logic                 in_byte, in_ack, stall, step, q3_step;
    logic                 sh_load, sh_shift, sh_msb, sh_last;
    logic [7:0]           sh_din;

    assign in_byte = state inside {ADDR, REG_HI, REG_LO, DATA};
    assign in_ack  = state inside {ACK_A, ACK_H, ACK_L, ACK_D};

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the quarter counter.
    assign stall = (qtr == 2'd2) && !scl_in && (in_byte || in_ack || state == STOP);
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall         = 1'b0;
`endif

    assign step     = strobe_400kHz && !stall;
    assign q3_step  = step && (qtr == 2'd3);
    assign sh_shift = q3_step && in_byte;
    assign sh_load  = q3_step && (state == START || in_ack);

    // Byte loaded on leaving START or an ACK slot is the one sent next.
    always_comb begin
        sh_din = data_q;
        case (state)
            START:   sh_din = {SLV_ADDR, 1'b0};
            ACK_A:   sh_din = addr_q[15:8];
            ACK_H:   sh_din = addr_q[7:0];
            default: sh_din = data_q;
        endcase
    end

    i2c_byte_shifter u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb),
        .last  (sh_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            qtr    <= '0;
            addr_q <= '0;
            data_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            nack   <= 1'b0;
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else begin
            done             <= 1'b0;
            {scl_oe, sda_oe} <= line_drive(state, qtr, sh_msb);
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        addr_q <= wr_addr;
                        data_q <= wr_data;
                        nack   <= 1'b0;
                        busy   <= 1'b1;
                        qtr    <= '0;
                        state  <= START;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (step) begin
                        qtr <= qtr + I2C_QTR_W'(1);
                        if (in_ack && qtr == 2'd2 && sda_in)
                            nack <= 1'b1;
                        // A NACK seen at q2 is already visible in nack by q3.
                        if (qtr == 2'd3) begin
                            case (state)
                                START:   state <= ADDR;
                                ADDR:    if (sh_last) state <= ACK_A;
                                ACK_A:   state <= nack ? STOP : REG_HI;
                                REG_HI:  if (sh_last) state <= ACK_H;
                                ACK_H:   state <= nack ? STOP : REG_LO;
                                REG_LO:  if (sh_last) state <= ACK_L;
                                ACK_L:   state <= nack ? STOP : DATA;
                                DATA:    if (sh_last) state <= ACK_D;
                                ACK_D:   state <= STOP;
                                STOP: begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_wr.sv
// Randomized bench for i2c_reg_wr: a bus-level monitor and ACK/NACK slave model decode
// SCL/SDA and compare against the expected byte sequence, strobe count and status flags.
module tb_i2c_reg_wr;

    localparam logic [6:0] SLV = 7'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe_400kHz = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        busy, done, nack, scl_oe, sda_oe, scl_in, sda_in;
    logic        slave_pull = 1'b0;
    logic        stretch_hold = 1'b0;

    assign scl_in = ~(scl_oe | stretch_hold);
    assign sda_in = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;

    i2c_reg_wr #(.SLV_ADDR(SLV)) dut (
        .clk           (clk),
        .reset         (reset),
        .strobe_400kHz (strobe_400kHz),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .nack          (nack),
        .scl_oe        (scl_oe),
        .sda_oe        (sda_oe),
        .scl_in        (scl_in),
        .sda_in        (sda_in)
    );

    int         errors = 0;
    int         checks = 0;
    int         strobe_per = 4;
    int         strobe_phase = 0;
    int         strobe_cnt = 0;
    bit         strobe_on = 0;
    bit         prev_scl = 1;
    bit         prev_sda = 1;
    int         bit_idx = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         nack_byte = 4;
    logic [7:0] cur_byte = '0;
    logic [7:0] rx_bytes[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Bus monitor plus slave: decode START/STOP/bits, pull SDA in ACK slots of acked bytes.
    task automatic decodeBus();
        if (prev_scl && scl_in && prev_sda && !sda_in) begin
            start_cnt++;
            bit_idx = 0;
        end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
            stop_cnt++;
        end else if (!prev_scl && scl_in) begin
            if (bit_idx % 9 != 8) begin
                cur_byte = {cur_byte[6:0], sda_in};
                if (bit_idx % 9 == 7) rx_bytes.push_back(cur_byte);
            end
            bit_idx++;
        end else if (prev_scl && !scl_in) begin
            if (bit_idx % 9 == 8 && bit_idx / 9 != nack_byte) slave_pull = 1'b1;
            if (bit_idx % 9 == 0) slave_pull = 1'b0;
        end
        prev_scl = scl_in;
        prev_sda = sda_in;
    endtask

    task automatic tick();
        strobe_400kHz = 1'b0;
        if (strobe_on) begin
            if (strobe_phase == strobe_per - 1) begin
                strobe_400kHz = 1'b1;
                strobe_phase  = 0;
                strobe_cnt++;
            end else begin
                strobe_phase++;
            end
        end
        @(negedge clk);
        decodeBus();
    endtask

    // One register write: nb = index of the byte the slave NACKs (4 = ack all).
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input int nb,
                                 input int per, input int spam_at, input int freeze,
                                 input bit req_on_done, input int stretch_at);
        logic [7:0] exp_bytes [4];
        int         nbytes, exp_strobes, clk_cnt, hold_left, extra;
        bit         done_seen, stretched;
        exp_bytes   = '{{SLV, 1'b0}, addr[15:8], addr[7:0], data};
        nbytes      = (nb < 4) ? nb + 1 : 4;
        exp_strobes = 4 * (9 * nbytes + 2);
        nack_byte   = nb;
        rx_bytes.delete();
        start_cnt = 0; stop_cnt = 0; bit_idx = 0;
        prev_scl = scl_in; prev_sda = sda_in;
        strobe_per = per; strobe_phase = 0; strobe_cnt = 0; strobe_on = 0;
        hold_left = 0; stretched = 0; extra = 0;

        wr_addr = addr; wr_data = data; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        checkOutput("busy_rise", busy, 1);
        checkOutput("nack_clear", nack, 0);

        repeat (freeze) tick();
        if (freeze > 0) begin
            checkOutput("freeze_busy", busy, 1);
            checkOutput("freeze_lines", {scl_oe, sda_oe}, 0);
            checkOutput("freeze_start", start_cnt, 0);
        end

        strobe_on = 1; done_seen = 0; clk_cnt = 0;
        while (!done_seen && clk_cnt < 4000) begin
            if (clk_cnt == spam_at) begin
                wr_addr = 16'hFFFF; wr_data = 8'hFF; wr_req = 1'b1;
            end
            tick();
            wr_req = 1'b0;
            clk_cnt++;
`ifdef I2C_CLK_STRETCH_EN
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) stretch_hold = 1'b0;
            end else if (stretch_at > 0 && !stretched && strobe_cnt == stretch_at) begin
                stretched    = 1;
                stretch_hold = 1'b1;
                hold_left    = 1000;
            end
`endif
            if (done) done_seen = 1;
        end
        strobe_on = 0;

        checkOutput("done_seen", done_seen, 1);
        checkOutput("done_busy_low", busy, 0);
        checkOutput("nack", nack, (nb < 4));
        checkOutput("lines_released", {scl_in, sda_in}, 2'b11);
`ifdef I2C_CLK_STRETCH_EN
        if (stretch_at > 0) begin
            extra = strobe_cnt - exp_strobes;
            checkOutput("stretch_extra_in_window",
                        (extra >= 1000 / per - 1 && extra <= 1000 / per + 1), 1);
        end else
`endif
        checkOutput("strobes", strobe_cnt, exp_strobes);
        checkOutput("byte_count", rx_bytes.size(), nbytes);
        for (int i = 0; i < nbytes && i < rx_bytes.size(); i++)
            checkOutput($sformatf("byte%0d", i), rx_bytes[i], exp_bytes[i]);
        checkOutput("starts", start_cnt, 1);
        checkOutput("stops", stop_cnt, 1);

        if (req_on_done) begin
            wr_addr = ~addr; wr_data = ~data; wr_req = 1'b1;
        end
        tick();
        wr_req = 1'b0;
        checkOutput("done_width", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("nack_hold", nack, (nb < 4));
    endtask

    task automatic resetMidTxn(input logic [15:0] addr, input logic [7:0] data);
        bit saw_done;
        nack_byte = 4; rx_bytes.delete(); bit_idx = 0;
        prev_scl = scl_in; prev_sda = sda_in;
        strobe_per = 3; strobe_phase = 0; strobe_cnt = 0; strobe_on = 0;
        wr_addr = addr; wr_data = data; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        strobe_on = 1;
        while (strobe_cnt < 77) tick();
        strobe_on = 0;
        tick();
        checkOutput("reg_lo_q1_lines", {scl_oe, sda_oe}, {1'b0, ~addr[7]});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        slave_pull = 1'b0;
        checkOutput("rst_lines", {scl_oe, sda_oe}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        saw_done = 0;
        strobe_on = 1;
        repeat (200) begin
            tick();
            if (done) saw_done = 1;
        end
        strobe_on = 0;
        checkOutput("rst_no_done", saw_done, 0);
        checkOutput("rst_stays_idle", {busy, scl_oe, sda_oe}, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_nack", nack, 0);
        checkOutput("reset_lines", {scl_oe, sda_oe}, 0);
        reset = 1'b0;
        tick();

        $display("[TB] directed: full write 0100/01");
        applyStimulus(16'h0100, 8'h01, 4, 4, -1, 0, 0, 0);
        $display("[TB] directed: address byte NACK");
        applyStimulus(16'h1234, 8'h56, 0, 3, -1, 0, 0, 0);
        $display("[TB] directed: request while busy is ignored");
        applyStimulus(16'h0A5C, 8'h3E, 4, 2, 40, 0, 0, 0);
        $display("[TB] directed: no strobes keeps engine frozen");
        applyStimulus(16'h8001, 8'h80, 2, 2, -1, 300, 0, 0);
        $display("[TB] directed: request on done cycle");
        applyStimulus(16'h00FF, 8'hC3, 4, 2, -1, 0, 1, 0);
        $display("[TB] directed: reset in REG_LO");
        resetMidTxn(16'h4B21, 8'h9D);

        for (int n = 0; n < 8; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          nb, spam;
            a    = 16'($urandom);
            d    = 8'($urandom);
            nb   = ($urandom_range(0, 1) == 1) ? 4 : int'($urandom_range(0, 3));
            spam = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 150)) : -1;
            applyStimulus(a, d, nb, int'($urandom_range(2, 5)), spam, 0, 0, 0);
        end

`ifdef I2C_CLK_STRETCH_EN
        $display("[TB] directed: clock stretch at DATA bit 3");
        applyStimulus(16'h0100, 8'h01, 4, 5, -1, 0, 0, 125);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_wr.md
I2C_REG_WR -- requirements
Module: i2c_reg_wr

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h10, 7-bit I2C slave address (camera sensor).
REQ-002 SHALL have port clk  input  1  system clock, 100MHz domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port strobe_400kHz  input  1  one-clk-wide tick, synchronous to clk, 250-clk period.
REQ-005 SHALL have port wr_req  input  1  start a register write; sampled only in IDLE.
REQ-006 SHALL have port wr_addr  input  16  sensor register address.
REQ-007 SHALL have port wr_data  input  8  register data.
REQ-008 SHALL have port busy  output  1  transaction in progress.
REQ-009 SHALL have port done  output  1  one-clk pulse at transaction end.
REQ-010 SHALL have port nack  output  1  valid with done; 1 = any ACK slot sampled high.
REQ-011 SHALL have ports scl_oe, sda_oe  output  1 each  1 = pull line low (open-drain), 0 = release.
REQ-012 SHALL have ports scl_in, sda_in  input  1 each  sampled pad levels.

Function
REQ-013 SHALL latch wr_addr/wr_data on the clk where wr_req=1 in IDLE; busy rises next clk.
REQ-014 SHALL ignore wr_req while busy=1 (no queueing, no latch update).
REQ-015 SHALL advance the bit engine only on clk cycles with strobe_400kHz=1; one bit = 4 quarters q0..q3 (SCL 100kHz).
REQ-016 SHALL use states IDLE, START, ADDR, ACK_A, REG_HI, ACK_H, REG_LO, ACK_L, DATA, ACK_D, STOP, DONE.
REQ-017 START: q0 both released, q1 sda_oe=1, q2 scl_oe=1, q3 hold -> ADDR.
REQ-018 data bits: q0 scl_oe=1 and sda_oe=~bit; q1,q2 scl released; q3 scl_oe=1; MSB first.
REQ-019 ADDR SHALL send {SLV_ADDR, 1'b0}; REG_HI wr_addr[15:8]; REG_LO wr_addr[7:0]; DATA wr_data.
REQ-020 ACK slots: sda released all quarters; sda_in sampled at q2; high -> set nack, go STOP after q3.
REQ-021 STOP: q0 scl_oe=1 sda_oe=1, q1 scl released, q2 hold, q3 sda released -> DONE.
REQ-022 DONE: done=1 for exactly one clk, busy=0 same clk, -> IDLE; nack holds until next wr_req accepted.
REQ-023 Full ACK'd write SHALL take 38 bit slots = 152 strobes (38000 clk at 250 clk/strobe) from START q0 to DONE.
REQ-024 Bit counter 3-bit, quarter counter 2-bit, both wrap to 0 at state change; no other arithmetic.
REQ-025 wr_req on the same clk as done SHALL be ignored (state is DONE, not IDLE).

Reset
REQ-026 reset=1 SHALL force on next clk: IDLE, busy=0, done=0, nack=0, scl_oe=0, sda_oe=0, counters 0.
REQ-027 reset mid-transaction SHALL abandon it without STOP and without done pulse.
REQ-028 reset SHALL take priority over strobe_400kHz and wr_req on the same clk.

Configuration
REQ-029 Macro I2C_CLK_STRETCH_EN defined: in q2 of any bit/ACK/STOP, engine SHALL stall (hold quarter) while scl_in=0.
REQ-030 Macro undefined: scl_in SHALL be ignored; timing strictly strobe-driven per REQ-023.

Structure
REQ-031 top_pkg SHALL hold i2c_state_t enum, I2C_QTR_W=2, I2C_BIT_W=3, and I2C_SLV_ADDR default.
REQ-032 one sub-module, i2c_byte_shifter (8-bit load/shift-left with bit counter), SHALL be instantiated once; FSM stays in i2c_reg_wr.

Verification
REQ-033 wr_addr=16'h0100, wr_data=8'h01, slave ACKs all -> SDA bytes 20,01,00,01; done after 152 strobes; nack=0.
REQ-034 slave NACKs address byte -> STOP follows ACK_A; done with nack=1; only 11 bit slots used.
REQ-035 wr_req pulsed again while busy with 16'hFFFF/8'hFF -> ignored; bytes on bus unchanged from first request.
REQ-036 reset asserted in REG_LO q1 -> next clk scl_oe=0, sda_oe=0, busy=0; no done pulse.
REQ-037 I2C_CLK_STRETCH_EN, slave holds scl_in=0 for 1000 clk at DATA bit 3 q2 -> total duration +1000 clk (+/- one strobe period); data intact.
REQ-038 strobe_400kHz tied 0 after wr_req -> busy=1, lines stay released, state frozen in START q0 indefinitely.
